// File: rtl/branch_cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_cmp_pkg
// Description : Shared types and helpers for the chunked sequential branch
//               comparator (FSM state encoding, result record, chunk count).
// Revision    : 1.0 - initial release
// ============================================================================
package branch_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bcmp_state_e;

    typedef struct packed {
        logic less;
        logic equal;
    } bcmp_res_t;

    // Number of CHUNK-wide slices that make up one WIDTH-bit operand.
    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage : branch_cmp_pkg
`default_nettype wire

// File: rtl/branch_cmp_seq_chunk_cmp.sv
`default_nettype none
// ============================================================================
// Module      : chunk_cmp
// Description : Combinational unsigned comparison of one CHUNK-bit slice.
//   i_a, i_b : slice of operand A / operand B
//   o_lt     : i_a < i_b (unsigned)
//   o_eq     : i_a == i_b
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    output logic             o_lt,
    output logic             o_eq
);

    assign o_lt = (i_a < i_b);
    assign o_eq = (i_a == i_b);

endmodule : chunk_cmp
`default_nettype wire

// File: rtl/branch_cmp_seq.sv
`default_nettype none
// ============================================================================
// Module      : branch_cmp_seq
// Description : Multi-cycle branch comparator. Compares two WIDTH-bit operands
//               CHUNK bits per cycle, most significant chunk first, signed or
//               unsigned, and returns less/equal over a valid/ready handshake.
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_flush               : abort any in-flight compare
//   i_valid / o_ready     : request handshake (o_ready only while idle)
//   i_rs1_data/i_rs2_data : operands A / B
//   i_br_un               : 1 = unsigned, 0 = signed compare
//   o_valid / i_ready     : result handshake, result held until consumed
//   o_br_less, o_br_equal : A < B, A == B (zero whenever o_valid is low)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cmp_seq
    import branch_cmp_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic             i_br_un,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_br_less,
    output logic             o_br_equal
);

    localparam int              NCHUNK     = nchunk(WIDTH, CHUNK);
    localparam int              IDX_W      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NCHUNK - 1);
    localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_width
            $error("branch_cmp_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    bcmp_state_e      r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, w_a_nxt;
    logic [WIDTH-1:0] r_b, w_b_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic             r_diff, w_diff_nxt;   // a differing chunk has been seen
    bcmp_res_t        r_res, w_res_nxt;     // result of the first difference
    bcmp_res_t        r_out, w_out_nxt;     // registered output flags
    logic             r_valid, w_valid_nxt;
    logic             r_ready, w_ready_nxt;

    // ------------------------------------------------------------------
    // Chunk select and compare (single shared comparator)
    // ------------------------------------------------------------------
    logic [CHUNK-1:0] w_ca, w_cb;
    logic             w_lt, w_eq;

    always_comb begin
        w_ca = '0;
        w_cb = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_ca = r_a[i*CHUNK +: CHUNK];
                w_cb = r_b[i*CHUNK +: CHUNK];
            end
        end
    end

    chunk_cmp #(
        .CHUNK (CHUNK)
    ) u_chunk_cmp (
        .i_a  (w_ca),
        .i_b  (w_cb),
        .o_lt (w_lt),
        .o_eq (w_eq)
    );

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    logic w_first;
    logic w_finish;

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_idx_nxt   = r_idx;
        w_diff_nxt  = r_diff;
        w_res_nxt   = r_res;
        w_out_nxt   = r_out;
        w_valid_nxt = r_valid;
        w_first     = 1'b0;
        w_finish    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    // Flipping the sign bit of both operands maps two's
                    // complement order onto unsigned order.
                    w_a_nxt            = i_rs1_data;
                    w_b_nxt            = i_rs2_data;
                    w_a_nxt[WIDTH-1]   = i_rs1_data[WIDTH-1] ^ ~i_br_un;
                    w_b_nxt[WIDTH-1]   = i_rs2_data[WIDTH-1] ^ ~i_br_un;
                    w_idx_nxt          = C_IDX_LAST;
                    w_diff_nxt         = 1'b0;
                    w_res_nxt          = '0;
                    w_state_nxt        = ST_RUN;
                end
            end

            ST_RUN: begin
                w_first  = !r_diff && !w_eq;
                w_finish = ((EARLY_EXIT != 0) && w_first) || (r_idx == '0);
                if (w_first) begin
                    w_diff_nxt      = 1'b1;
                    w_res_nxt.less  = w_lt;
                    w_res_nxt.equal = 1'b0;
                end
                if (w_finish) begin
                    w_state_nxt = ST_DONE;
                    w_valid_nxt = 1'b1;
                    if (w_first) begin
                        w_out_nxt.less  = w_lt;
                        w_out_nxt.equal = 1'b0;
                    end else if (r_diff) begin
                        w_out_nxt = r_res;
                    end else begin
                        w_out_nxt.less  = 1'b0;
                        w_out_nxt.equal = 1'b1;
                    end
                end else begin
                    w_idx_nxt = r_idx - C_IDX_ONE;
                end
            end

            ST_DONE: begin
                // Returning to IDLE here blocks any same-cycle accept.
                if (i_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                    w_out_nxt   = '0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_out_nxt   = '0;
            end
        endcase

        // Branch kill overrides accept and result consumption.
        if (i_flush) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = C_IDX_LAST;
            w_diff_nxt  = 1'b0;
            w_res_nxt   = '0;
            w_out_nxt   = '0;
            w_valid_nxt = 1'b0;
        end

        w_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= C_IDX_LAST;
            r_diff  <= 1'b0;
            r_res   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_idx   <= w_idx_nxt;
            r_diff  <= w_diff_nxt;
            r_res   <= w_res_nxt;
            r_out   <= w_out_nxt;
            r_valid <= w_valid_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    assign o_ready    = r_ready;
    assign o_valid    = r_valid;
    assign o_br_less  = r_out.less;
    assign o_br_equal = r_out.equal;

endmodule : branch_cmp_seq
`default_nettype wire

// File: tb/tb_branch_cmp_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_cmp_seq
// Description : Self-checking bench. dut0 (32/8, early exit) and dut1
//               (32/8, fixed latency) share stimulus; dut2 (64/16) takes a
//               random sweep checked against a behavioural compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_cmp_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, valid, ready, br_un;
    logic [31:0] a, b;
    logic        rdy0, val0, less0, eq0;
    logic        rdy1, val1, less1, eq1;

    logic        valid2, ready2, un2;
    logic [63:0] a2, b2;
    logic        rdy2, val2, less2, eq2;

    int checks = 0;
    int errors = 0;

    branch_cmp_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_valid(valid), .o_ready(rdy0),
        .i_rs1_data(a), .i_rs2_data(b), .i_br_un(br_un), .o_valid(val0), .i_ready(ready),
        .o_br_less(less0), .o_br_equal(eq0));

    branch_cmp_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_valid(valid), .o_ready(rdy1),
        .i_rs1_data(a), .i_rs2_data(b), .i_br_un(br_un), .o_valid(val1), .i_ready(ready),
        .o_br_less(less1), .o_br_equal(eq1));

    branch_cmp_seq #(.WIDTH(64), .CHUNK(16), .EARLY_EXIT(1)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_valid(valid2), .o_ready(rdy2),
        .i_rs1_data(a2), .i_rs2_data(b2), .i_br_un(un2), .o_valid(val2), .i_ready(ready2),
        .o_br_less(less2), .o_br_equal(eq2));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        un;
        logic        less;
        logic        equal;
        int          lat_ee;   // latency with early exit
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request to dut0/dut1; optional backpressure hold before consuming.
    task automatic run_pair(input vec_t v, input int hold, input string tag);
        int  l0, l1;
        bit  stable;
        @(negedge clk);
        chk({tag, " idle"}, 64'({rdy0, rdy1, val0, val1}), 64'b1100);
        a = v.a; b = v.b; br_un = v.un; valid = 1'b1; ready = 1'b0;
        @(posedge clk); @(negedge clk);
        // Junk request held high: must be ignored while busy.
        a = ~v.a; b = v.a; br_un = ~v.un;
        chk({tag, " busy"}, 64'({rdy0, rdy1, val0, val1}), 64'b0000);
        l0 = 0; l1 = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); @(negedge clk);
            if (val0 && l0 == 0) l0 = c;
            if (val1 && l1 == 0) l1 = c;
            if (l0 != 0 && l1 != 0) break;
        end
        chk({tag, " lat_ee1"}, 64'(l0), 64'(v.lat_ee));
        chk({tag, " lat_ee0"}, 64'(l1), 64'd4);
        chk({tag, " flags_ee1"}, 64'({less0, eq0}), 64'({v.less, v.equal}));
        chk({tag, " flags_ee0"}, 64'({less1, eq1}), 64'({v.less, v.equal}));
        if (hold > 0) begin
            stable = 1'b1;
            for (int c = 0; c < hold; c++) begin
                @(posedge clk); @(negedge clk);
                if (!(val0 && val1 && !rdy0 && !rdy1 &&
                      {less0, eq0, less1, eq1} == {v.less, v.equal, v.less, v.equal}))
                    stable = 1'b0;
            end
            chk({tag, " hold_stable"}, 64'(stable), 64'd1);
        end
        ready = 1'b1;
        @(posedge clk); @(negedge clk);
        ready = 1'b0;
        chk({tag, " consumed"}, 64'({rdy0, rdy1, val0, val1, less0, eq0, less1, eq1}),
            64'b11000000);
        valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk({tag, " no_accept_on_handshake"}, 64'({rdy0, rdy1, val0, val1}), 64'b1100);
    endtask

    // Start an equal-operand compare, kill it when idx has reached 2.
    task automatic abort_run(input bit use_rst, input string tag);
        bit seen;
        @(negedge clk);
        a = 32'h12345678; b = 32'h12345678; br_un = 1'b0; valid = 1'b1; ready = 1'b0;
        @(posedge clk); @(negedge clk);
        valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk({tag, " mid_run"}, 64'({rdy0, rdy1, val0, val1}), 64'b0000);
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; flush = 1'b0;
        chk({tag, " idle_after"}, 64'({rdy0, rdy1, val0, val1, less0, eq0, less1, eq1}),
            64'b11000000);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); @(negedge clk);
            if (val0 || val1 || !rdy0 || !rdy1) seen = 1'b1;
        end
        chk({tag, " no_result"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic        exp_less;
        int          lat;
        rst = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b0; br_un = 1'b0;
        a = '0; b = '0;
        valid2 = 1'b0; ready2 = 1'b0; un2 = 1'b0; a2 = '0; b2 = '0;

        vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0, 1};
        vecs[1]  = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, 1};
        vecs[2]  = '{32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b1, 4};
        vecs[3]  = '{32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 1};
        vecs[4]  = '{32'h12345678, 32'h12345679, 1'b1, 1'b1, 1'b0, 4};
        vecs[5]  = '{32'h12345678, 32'h12335678, 1'b1, 1'b0, 1'b0, 2};
        vecs[6]  = '{32'h00001000, 32'h00002000, 1'b0, 1'b1, 1'b0, 3};
        vecs[7]  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 4};
        vecs[8]  = '{32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0, 1'b0, 1};
        vecs[9]  = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 1'b0, 1};
        vecs[10] = '{32'h01000000, 32'h00FFFFFF, 1'b1, 1'b0, 1'b0, 1};
        vecs[11] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1, 4};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("reset_state", 64'({rdy0, val0, less0, eq0, rdy1, val1, less1, eq1, rdy2, val2, less2, eq2}),
            64'b100010001000);

        foreach (vecs[i]) run_pair(vecs[i], 0, $sformatf("vec%0d", i));

        run_pair(vecs[0], 5, "backpressure");

        // Flush in the same cycle as a request: request is dropped.
        @(negedge clk);
        a = 32'h1; b = 32'h2; br_un = 1'b1; valid = 1'b1; flush = 1'b1;
        @(posedge clk); @(negedge clk);
        valid = 1'b0; flush = 1'b0;
        chk("flush_beats_accept", 64'({rdy0, rdy1, val0, val1}), 64'b1100);

        abort_run(1'b0, "flush_mid_run");
        run_pair(vecs[4], 0, "after_flush");
        abort_run(1'b1, "reset_mid_run");
        run_pair(vecs[7], 0, "after_reset");

        // Random sweep on the 64/16 instance.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a2 = {$urandom, $urandom};
            case (i % 4)
                0:       b2 = a2;
                1:       b2 = a2 ^ 64'($urandom_range(1, 65535));
                2:       b2 = a2 ^ 64'h8000_0000_0000_0000;
                default: b2 = {$urandom, $urandom};
            endcase
            un2 = 1'($urandom_range(0, 1));
            exp_less = un2 ? (a2 < b2) : ($signed(a2) < $signed(b2));
            valid2 = 1'b1; ready2 = 1'b0;
            @(posedge clk); @(negedge clk);
            valid2 = 1'b0;
            lat = 0;
            for (int c = 1; c <= 8; c++) begin
                @(posedge clk); @(negedge clk);
                if (val2) begin lat = c; break; end
            end
            chk($sformatf("sweep%0d_valid", i), 64'(lat != 0), 64'd1);
            chk($sformatf("sweep%0d_flags", i), 64'({less2, eq2}), 64'({exp_less, a2 == b2}));
            ready2 = 1'b1;
            @(posedge clk); @(negedge clk);
            ready2 = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_branch_cmp_seq
`default_nettype wire
